// File: rtl/switch_pkg.sv
// switch_pkg: shared types, sizes and priority-encode helper for the switch encoder
package switch_pkg;
  localparam int SWITCH_COUNT = 8;
  localparam int CODE_WIDTH = 3;
  typedef enum logic {IDLE, PENDING} enc_state_t;
  function automatic logic [CODE_WIDTH-1:0] msb_index(input logic [SWITCH_COUNT-1:0] v);
    logic [CODE_WIDTH-1:0] code;
    code = '0;
    for (int i = 0; i < SWITCH_COUNT; i++) code = v[i] ? CODE_WIDTH'(i) : code;
    return code;
  endfunction
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus whole-vector debounce of the raw switches
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SWITCH_COUNT-1:0] switches,
  output logic [SWITCH_COUNT-1:0] switches_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SWITCH_COUNT-1:0] meta, sync, candidate;
  logic [CW-1:0] count;
  // any difference in any bit restarts the count for the whole vector
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta <= '0;
      sync <= '0;
      candidate <= '0;
      count <= '0;
      switches_stable <= '0;
    end else begin
      meta <= switches;
      sync <= meta;
      if (sync != candidate) begin
        candidate <= sync;
        count <= '0;
      end else if (count < LAST) count <= count + CW'(1);
      else switches_stable <= candidate;
    end
  end
endmodule

// File: rtl/switch_encoder_8to3.sv
// switch_encoder_8to3: debounced switches priority-encoded and reported as coalesced valid/ready events
module switch_encoder_8to3
  import switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SWITCH_COUNT-1:0] switches,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [CODE_WIDTH-1:0]   out_code,
  output logic                    out_present,
  output logic [SWITCH_COUNT-1:0] switches_stable
);
  enc_state_t state;
  logic enc_present, last_present;
  logic [CODE_WIDTH-1:0] enc_code, last_code;
  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debouncer (
    .clock(clock),
    .reset(reset),
    .switches(switches),
    .switches_stable(switches_stable)
  );
  assign enc_present = |switches_stable;
  assign enc_code = msb_index(switches_stable);
  // changes seen while PENDING are not queued; IDLE re-compares against the last accepted pair
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_code <= '0;
      out_present <= 1'b0;
      last_code <= '0;
      last_present <= 1'b0;
    end else if (state == IDLE) begin
      if ({enc_present, enc_code} != {last_present, last_code}) begin
        out_code <= enc_code;
        out_present <= enc_present;
        out_valid <= 1'b1;
        state <= PENDING;
      end
    end else if (out_ready) begin
      last_code <= out_code;
      last_present <= out_present;
      out_valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_switch_encoder_8to3.sv
// tb_switch_encoder_8to3: scenario tasks with a scoreboard of expected {present, code} events
module tb_switch_encoder_8to3;
  localparam int D = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [7:0] switches = 8'h00;
  logic out_ready = 1'b0;
  logic out_valid, out_present;
  logic [2:0] out_code;
  logic [7:0] switches_stable;
  int total = 0;
  int bad = 0;
  logic [3:0] sb[$];

  switch_encoder_8to3 #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock),
    .reset(reset),
    .switches(switches),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_code(out_code),
    .out_present(out_present),
    .switches_stable(switches_stable)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic pop_compare(input string name);
    logic [3:0] exp;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h but scoreboard empty", name, {out_present, out_code});
    end else begin
      exp = sb.pop_front();
      if ({out_present, out_code} !== exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", name, {out_present, out_code}, exp);
      end
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: out_valid got %b want 0", name, out_valid);
    end
  endtask

  task automatic quiet(input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      seen |= out_valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL %s: unexpected event seen=%b want 0", name, seen);
    end
  endtask

  task automatic test_idle_after_reset(input string name);
    logic [12:0] acc;
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      acc |= {out_valid, out_present, out_code, switches_stable};
    end
    total++;
    if (acc !== 13'h0) begin
      bad++;
      $display("FAIL %s: outputs or-ed got %h want 0", name, acc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    switches = 8'h00;
    out_ready = 1'b0;
    repeat (3) step();
    total++;
    if ({out_valid, out_present, out_code, switches_stable} !== 13'h0) begin
      bad++;
      $display("FAIL reset_values: got %h want 0", {out_valid, out_present, out_code, switches_stable});
    end
    reset = 1'b1;
    test_idle_after_reset("reset_idle");
  endtask

  task automatic test_latency();
    switches = 8'h05;
    sb.push_back({1'b1, 3'd2});
    repeat (D + 2) step();
    total++;
    if (switches_stable !== 8'h00) begin
      bad++;
      $display("FAIL lat_early_stable: got %h want 00", switches_stable);
    end
    step();
    total++;
    if (switches_stable !== 8'h05 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_stable: got %h/%b want 05/0", switches_stable, out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL lat_valid: got %b want 1", out_valid);
    end
    pop_compare("lat_event");
    handshake("lat_handshake");
    quiet(10, "lat_no_repeat");
  endtask

  task automatic test_glitch();
    int n;
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      switches = switches ^ 8'h80;
      repeat (5) begin
        step();
        seen |= out_valid;
      end
    end
    total++;
    if (seen !== 1'b0 || switches_stable !== 8'h05) begin
      bad++;
      $display("FAIL glitch_filtered: event=%b stable=%h want 0/05", seen, switches_stable);
    end
    switches = 8'h85;
    sb.push_back({1'b1, 3'd7});
    wait_valid(60, n);
    total++;
    if (n !== D + 4) begin
      bad++;
      $display("FAIL glitch_latency: got %0d edges want %0d", n, D + 4);
    end
    pop_compare("glitch_event");
    handshake("glitch_handshake");
    quiet(30, "glitch_single");
  endtask

  task automatic test_coalesce();
    int n;
    logic held;
    held = 1'b1;
    switches = 8'h01;
    sb.push_back({1'b1, 3'd0});
    wait_valid(60, n);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL coal_first: out_valid got %b want 1", out_valid);
    end
    pop_compare("coal_first_event");
    repeat (5) step();
    switches = 8'h10;
    for (int i = 0; i < 25; i++) begin
      step();
      held &= (out_valid === 1'b1 && out_code === 3'd0 && out_present === 1'b1);
    end
    switches = 8'h40;
    sb.push_back({1'b1, 3'd6});
    for (int i = 0; i < 25; i++) begin
      step();
      held &= (out_valid === 1'b1 && out_code === 3'd0 && out_present === 1'b1);
    end
    total++;
    if (held !== 1'b1 || switches_stable !== 8'h40) begin
      bad++;
      $display("FAIL coal_hold: held=%b stable=%h want 1/40", held, switches_stable);
    end
    handshake("coal_handshake1");
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL coal_second: out_valid got %b want 1", out_valid);
    end
    pop_compare("coal_second_event");
    handshake("coal_handshake2");
    quiet(30, "coal_no_third");
  endtask

  task automatic test_no_event();
    int n;
    switches = 8'h10;
    sb.push_back({1'b1, 3'd4});
    wait_valid(60, n);
    pop_compare("noev_setup_event");
    handshake("noev_setup_handshake");
    switches = 8'h18;
    quiet(30, "noev_lower_bit");
    total++;
    if (switches_stable !== 8'h18) begin
      bad++;
      $display("FAIL noev_stable: got %h want 18", switches_stable);
    end
    switches = 8'h00;
    sb.push_back({1'b0, 3'd0});
    wait_valid(60, n);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL noev_off_valid: got %b want 1", out_valid);
    end
    pop_compare("noev_off_event");
    handshake("noev_off_handshake");
  endtask

  task automatic test_reset_mid();
    int n;
    switches = 8'h02;
    sb.push_back({1'b1, 3'd1});
    wait_valid(60, n);
    pop_compare("rmid_event");
    switches = 8'h00;
    reset = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || switches_stable !== 8'h00) begin
      bad++;
      $display("FAIL rmid_cleared: valid=%b stable=%h want 0/00", out_valid, switches_stable);
    end
    reset = 1'b1;
    test_idle_after_reset("rmid_idle");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_coalesce();
    test_no_event();
    test_reset_mid();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drained: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
